ipsl_pcie_dma_cpld_rd_fetch: RTL and testbench

- Sits between the BAR data RAM and the completion TX controller.
- Serves each rd_en/length/address request from the TX controller by reading 128-bit RAM words (1-cycle read latency).
- Realigns the words to the DW offset of the byte address, so data starts at DW0 of a beat, and streams beats with start, data and last strobes.
- Honours the TX hold back-pressure without bubbles or data loss.

---
 rtl/ipsl_pcie_dma_pkg.sv | 19 +
 rtl/ipsl_pcie_dma_rd_word_fifo.sv | 65 ++++++
 rtl/ipsl_pcie_dma_cpld_rd_fetch.sv | 148 ++++++++++++++
 tb/tb_ipsl_pcie_dma_cpld_rd_fetch.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ipsl_pcie_dma_pkg.sv
// rtl/ipsl_pcie_dma_pkg.sv - shared types and constants for the PCIe DMA read path
package ipsl_pcie_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } rd_state_e;

  localparam int DW_PER_BEAT = 4;
  localparam int MAX_LEN_DW  = 1024;

  // Number of 4-DW units needed to cover n DWs (n <= 1027 gives at most 257)
  function automatic logic [8:0] ceil_div4(input logic [11:0] n);
    return 9'((n + 12'(DW_PER_BEAT - 1)) / 12'(DW_PER_BEAT));
  endfunction

endpackage

// File: rtl/ipsl_pcie_dma_rd_word_fifo.sv
// rtl/ipsl_pcie_dma_rd_word_fifo.sv - registered prefetch FIFO exposing the two head words
module ipsl_pcie_dma_rd_word_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [127:0]           push_data_i,
  input  logic [1:0]             pop_cnt_i,
  output logic [127:0]           head_o,
  output logic [127:0]           head1_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [127:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr1;

  assign rd_ptr1 = rd_ptr_q + AW'(1);
  assign head_o  = mem_q[rd_ptr_q];
  assign head1_o = mem_q[rd_ptr1];
  assign count_o = count_q;

  // Pointer and occupancy next-state; a flush discards everything including a same-cycle push
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push_i);
      rd_ptr_d = rd_ptr_q + AW'(pop_cnt_i);
      count_d  = count_q + (AW+1)'(push_i) - (AW+1)'(pop_cnt_i);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Word storage; contents are only meaningful below count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ipsl_pcie_dma_cpld_rd_fetch.sv
// rtl/ipsl_pcie_dma_cpld_rd_fetch.sv - BAR RAM read, DW realign and beat streaming for completions
module ipsl_pcie_dma_cpld_rd_fetch
  import ipsl_pcie_dma_pkg::*;
#(
  parameter int RAM_ADDR_W = 10,
  parameter int PF_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rd_en,
  input  logic [9:0]            i_rd_length,
  input  logic [63:0]           i_rd_addr,
  input  logic                  i_cpld_tx_hold,
  input  logic                  i_cpld_tlp_tx,
  output logic                  o_gen_tlp_start,
  output logic [127:0]          o_rd_data,
  output logic                  o_last_data,
  output logic                  o_ram_rd_en,
  output logic [RAM_ADDR_W-1:0] o_ram_rd_addr,
  input  logic [127:0]          i_ram_rd_data
);

  localparam int CW = $clog2(PF_DEPTH) + 1;

  rd_state_e             state_q;
  logic [RAM_ADDR_W-1:0] ptr_q;
  logic [1:0]            shift_q;
  logic [8:0]            beats_q;
  logic [8:0]            words_q;
  logic [8:0]            words_left_q;
  logic [8:0]            beat_idx_q;
  logic                  inflight_q;

  logic [127:0] head0, head1, upper;
  logic [255:0] pair;
  logic [127:0] beat;
  logic [CW-1:0] fifo_count, occ;
  logic          active, fetch, need_two, beat_valid, is_last, consume;
  logic          push, flush;
  logic [1:0]    pop_cnt;
  logic [11:0]   len_full;
  logic          unused_addr;

  assign unused_addr = ^{i_rd_addr[63:RAM_ADDR_W+4], i_rd_addr[1:0]};

  assign active   = (state_q == ST_FILL) || (state_q == ST_STREAM);
  assign occ      = fifo_count + CW'(inflight_q);
  assign fetch    = active && i_rd_en && (words_left_q != 9'd0) && (occ < CW'(PF_DEPTH));

  // A shifted beat needs the following word too, unless this beat sits on the last word
  assign need_two   = (shift_q != 2'd0) && ((beat_idx_q + 9'd1) < words_q);
  assign beat_valid = need_two ? (fifo_count >= CW'(2)) : (fifo_count != '0);
  assign is_last    = (beat_idx_q == beats_q - 9'd1);
  assign consume    = i_cpld_tlp_tx && !i_cpld_tx_hold && o_gen_tlp_start;

  // The final beat drops both words it straddles; otherwise the upper word is kept for the next beat
  assign pop_cnt = !consume ? 2'd0 : ((is_last && need_two) ? 2'd2 : 2'd1);
  assign push    = inflight_q && active;
  assign flush   = active && !i_rd_en;

  ipsl_pcie_dma_rd_word_fifo #(.DEPTH(PF_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (i_ram_rd_data),
    .pop_cnt_i   (pop_cnt),
    .head_o      (head0),
    .head1_o     (head1),
    .count_o     (fifo_count)
  );

  assign upper = need_two ? head1 : 128'd0;
  assign pair  = {upper, head0};

  // Realign so the first requested DW lands in DW0 of the beat
  always_comb begin
    beat = head0;
    case (shift_q)
      2'd1:    beat = pair[159:32];
      2'd2:    beat = pair[191:64];
      2'd3:    beat = pair[223:96];
      default: beat = head0;
    endcase
  end

  assign o_gen_tlp_start = active && beat_valid;
  assign o_rd_data       = o_gen_tlp_start ? beat : 128'd0;
  assign o_last_data     = o_gen_tlp_start && is_last;
  assign o_ram_rd_en     = fetch;
  assign o_ram_rd_addr   = fetch ? ptr_q : '0;

  assign len_full = (i_rd_length == 10'd0) ? 12'(MAX_LEN_DW) : {2'b00, i_rd_length};

  // Request FSM with fetch pointer, word/beat counters and in-flight tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      shift_q      <= '0;
      beats_q      <= '0;
      words_q      <= '0;
      words_left_q <= '0;
      beat_idx_q   <= '0;
      inflight_q   <= 1'b0;
    end else begin
      inflight_q <= fetch;
      case (state_q)
        ST_IDLE: begin
          if (i_rd_en) begin
            ptr_q        <= i_rd_addr[RAM_ADDR_W+3:4];
            shift_q      <= i_rd_addr[3:2];
            beats_q      <= ceil_div4(len_full);
            words_q      <= ceil_div4(len_full + {10'd0, i_rd_addr[3:2]});
            words_left_q <= ceil_div4(len_full + {10'd0, i_rd_addr[3:2]});
            beat_idx_q   <= '0;
            state_q      <= ST_FILL;
          end
        end
        ST_FILL, ST_STREAM: begin
          if (!i_rd_en) begin
            state_q <= ST_IDLE;
          end else begin
            if (fetch) begin
              ptr_q        <= ptr_q + RAM_ADDR_W'(1);
              words_left_q <= words_left_q - 9'd1;
            end
            if (consume) begin
              beat_idx_q <= beat_idx_q + 9'd1;
            end
            if (consume && is_last) begin
              state_q <= ST_DONE;
            end else if (state_q == ST_FILL && beat_valid) begin
              state_q <= ST_STREAM;
            end
          end
        end
        ST_DONE: begin
          if (!i_rd_en) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipsl_pcie_dma_cpld_rd_fetch.sv
// tb/tb_ipsl_pcie_dma_cpld_rd_fetch.sv - table-driven bench for the completion read fetch block
module tb_ipsl_pcie_dma_cpld_rd_fetch;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_rd_en = 1'b0;
  logic [9:0]   i_rd_length = '0;
  logic [63:0]  i_rd_addr = '0;
  logic         i_cpld_tx_hold = 1'b0;
  logic         i_cpld_tlp_tx = 1'b0;
  logic         o_gen_tlp_start;
  logic [127:0] o_rd_data;
  logic         o_last_data;
  logic         o_ram_rd_en;
  logic [9:0]   o_ram_rd_addr;
  logic [127:0] i_ram_rd_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ipsl_pcie_dma_cpld_rd_fetch #(.RAM_ADDR_W(10), .PF_DEPTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_rd_en         (i_rd_en),
    .i_rd_length     (i_rd_length),
    .i_rd_addr       (i_rd_addr),
    .i_cpld_tx_hold  (i_cpld_tx_hold),
    .i_cpld_tlp_tx   (i_cpld_tlp_tx),
    .o_gen_tlp_start (o_gen_tlp_start),
    .o_rd_data       (o_rd_data),
    .o_last_data     (o_last_data),
    .o_ram_rd_en     (o_ram_rd_en),
    .o_ram_rd_addr   (o_ram_rd_addr),
    .i_ram_rd_data   (i_ram_rd_data)
  );

  function automatic logic [127:0] ram_word(input int w);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[32*j +: 32] = 32'hA500_0000 | (32'(w) << 8) | 32'(j);
    return r;
  endfunction

  // RAM with one cycle of read latency
  always @(posedge clk) begin
    if (o_ram_rd_en) i_ram_rd_data <= ram_word(int'(o_ram_rd_addr));
  end

  // Expected beat k built from the global DW index of each lane
  function automatic logic [127:0] exp_beat(input logic [63:0] addr, input logic [9:0] len, input int k);
    int sh, sw, l, words, g, w;
    logic [127:0] r, wd;
    sh = int'(addr[3:2]);
    sw = int'(addr[13:4]);
    l = (len == 10'd0) ? 1024 : int'(len);
    words = (sh + l + 3) / 4;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      g = sh + 4 * k + i;
      w = g / 4;
      if (w < words) begin
        wd = ram_word((sw + w) % 1024);
        r[32*i +: 32] = wd[32*(g % 4) +: 32];
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  typedef struct {
    logic [9:0]  len;
    logic [63:0] addr;
    int          beats;
    int          reads;
    int          hold_beat;
    int          hold_cyc;
    int          abort_beat;
    int          rst_beat;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int k = 0, nreads = 0, cyc = 0, bubbles = 0, hold_used = 0, max_occ = 0, lastbad = 0, sw;
    bit done = 0, started = 0;
    sw = int'(v.addr[13:4]);
    @(negedge clk);
    i_rd_addr = v.addr;
    i_rd_length = v.len;
    i_cpld_tx_hold = 1'b0;
    i_cpld_tlp_tx = 1'b1;
    i_rd_en = 1'b1;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (v.abort_beat >= 0 && k == v.abort_beat) begin
        i_rd_en = 1'b0;
        i_cpld_tlp_tx = 1'b0;
        i_cpld_tx_hold = 1'b0;
        @(negedge clk);
        #1;
        check("abort_outputs", {o_gen_tlp_start, o_last_data, o_ram_rd_en, o_rd_data}, '0);
        return;
      end
      if (v.rst_beat >= 0 && k == v.rst_beat) begin
        rst_n = 1'b0;
        #1;
        check("reset_outputs", {o_gen_tlp_start, o_last_data, o_ram_rd_en, o_ram_rd_addr, o_rd_data}, '0);
        @(negedge clk);
        i_rd_en = 1'b0;
        i_cpld_tlp_tx = 1'b0;
        i_cpld_tx_hold = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      i_cpld_tx_hold = (k == v.hold_beat) && (hold_used < v.hold_cyc);
      if (i_cpld_tx_hold) hold_used++;
      #1;
      if (o_last_data && !o_gen_tlp_start) lastbad++;
      if (o_ram_rd_en) begin
        check("rd_addr", 128'(o_ram_rd_addr), 128'((sw + nreads) % 1024));
        nreads++;
      end
      if (nreads - k > max_occ) max_occ = nreads - k;
      if (o_gen_tlp_start) begin
        if (!started) begin
          started = 1;
          check("start_latency_ge3", 128'(cyc >= 3), 128'(1));
        end
        check("beat_data", o_rd_data, exp_beat(v.addr, v.len, k));
        check("last_flag", 128'(o_last_data), 128'(k == v.beats - 1));
        if (!i_cpld_tx_hold) begin
          k++;
          if (k == v.beats) done = 1;
        end
      end else if (started) begin
        bubbles++;
      end
    end
    check("completed", 128'(done), 128'(1));
    check("beat_count", 128'(k), 128'(v.beats));
    check("read_count", 128'(nreads), 128'(v.reads));
    check("no_bubbles", 128'(bubbles), 128'(0));
    check("occupancy_le_depth", 128'(max_occ <= 4), 128'(1));
    check("last_without_start", 128'(lastbad), 128'(0));
    i_cpld_tx_hold = 1'b0;
    @(negedge clk);
    #1;
    check("done_outputs", {o_gen_tlp_start, o_last_data, o_ram_rd_en, o_rd_data}, '0);
    i_rd_en = 1'b0;
    i_cpld_tlp_tx = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("idle_outputs", {o_gen_tlp_start, o_last_data, o_ram_rd_en, o_rd_data}, '0);
  endtask

  vec_t vecs[10];

  initial begin
    //        len     addr        beats reads hold_b hold_c abort rst
    vecs[0] = '{10'd8,  64'h0040, 2,   2,   -1, 0, -1, -1};
    vecs[1] = '{10'd5,  64'h000C, 2,   2,   -1, 0, -1, -1};
    vecs[2] = '{10'd3,  64'h0008, 1,   2,   -1, 0, -1, -1};
    vecs[3] = '{10'd32, 64'h0200, 8,   8,    3, 3, -1, -1};
    vecs[4] = '{10'd16, 64'h001C, 4,   5,    0, 2, -1, -1};
    vecs[5] = '{10'd0,  64'h3F80, 256, 256, -1, 0, -1, -1};
    vecs[6] = '{10'd32, 64'h0084, 8,   9,   -1, 0,  2, -1};
    vecs[7] = '{10'd4,  64'h0100, 1,   1,   -1, 0, -1, -1};
    vecs[8] = '{10'd32, 64'h0040, 8,   8,   -1, 0, -1,  2};
    vecs[9] = '{10'd8,  64'h0040, 2,   2,   -1, 0, -1, -1};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", {o_gen_tlp_start, o_last_data, o_ram_rd_en, o_ram_rd_addr, o_rd_data}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle_after_reset", {o_gen_tlp_start, o_last_data, o_ram_rd_en, o_ram_rd_addr, o_rd_data}, '0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
